// File: rtl/mu0_pkg.sv
// Shared types and widths for the MU0 memory responder slice.
package mu0_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_ST = 2'd1,
        RESP    = 2'd2
    } state_e;

endpackage

// File: rtl/mu0_mem_responder_if.sv
// MU0 datapath memory bus: the initiator drives Addr/WData/Rd/Wr, the responder answers.
interface mu0_mem_responder_if;
    import mu0_pkg::*;

    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WData;
    logic              Rd;
    logic              Wr;
    logic [DATA_W-1:0] RData;
    logic              Ready;
    logic              Err;
    logic              Busy;

    modport master (
        output Addr, WData, Rd, Wr,
        input  RData, Ready, Err, Busy
    );

    modport slave (
        input  Addr, WData, Rd, Wr,
        output RData, Ready, Err, Busy
    );

endinterface

// File: rtl/mu0_mem_array.sv
// Single-port word store: synchronous write, registered read; storage is never reset.
module mu0_mem_array
    import mu0_pkg::*;
#(
    parameter int MEM_AW = 8
) (
    input  logic              Clk,
    input  logic              we,
    input  logic              re,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**MEM_AW];

    // Write port and registered read port share one address.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/mu0_mem_responder.sv
// MU0 memory responder: latches one request, inserts WAIT wait states, then pulses Ready.
module mu0_mem_responder
    import mu0_pkg::*;
#(
    parameter int MEM_AW = 8,
    parameter int WAIT   = 1
) (
    input  logic Clk,
    input  logic Reset,
    mu0_mem_responder_if.slave bus
);

    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                rdv_q, rdv_d;

    logic                req_s;
    logic                ill_s;
    logic                enter_resp_s;
    logic                mem_we_s;
    logic                mem_re_s;
    logic [DATA_W-1:0]   mem_rdata_s;

    assign req_s = bus.Rd ^ bus.Wr;
    assign ill_s = bus.Rd & bus.Wr;

    if (MEM_AW < ADDR_W) begin : g_alias
        logic addr_unused_s;
        assign addr_unused_s = ^bus.Addr[ADDR_W-1:MEM_AW];
    end

    // State, request latches and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            addr_q  <= {MEM_AW{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdv_q   <= rdv_d;
        end
    end

    // Next state, wait counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    addr_d  = bus.Addr[MEM_AW-1:0];
                    wdata_d = bus.WData;
                    wr_d    = bus.Wr;
                    if (WAIT_C == {CNT_W{1'b0}}) begin
                        state_d = RESP;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = WAIT_ST;
                        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_ST: begin
                if (cnt_q >= WAIT_C) begin
                    state_d = RESP;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs and array strobes; the array is accessed on the edge that enters RESP.
    always_comb begin
        enter_resp_s = (state_d == RESP) && !Reset;
        mem_we_s     = enter_resp_s && wr_d;
        mem_re_s     = enter_resp_s && !wr_d;
        ready_d      = (state_d == RESP);
        busy_d       = (state_d != IDLE);
        err_d        = (state_q == IDLE) && ill_s;
        rdv_d        = rdv_q | mem_re_s;
    end

    mu0_mem_array #(
        .MEM_AW (MEM_AW)
    ) u_array (
        .Clk   (Clk),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .addr  (addr_d),
        .wdata (wdata_d),
        .rdata (mem_rdata_s)
    );

    // Array storage has no reset, so RData reads zero until the first completed read.
    assign bus.RData = rdv_q ? mem_rdata_s : {DATA_W{1'b0}};
    assign bus.Ready = ready_q;
    assign bus.Err   = err_q;
    assign bus.Busy  = busy_q;

endmodule
